// File: rtl/lsu_pkg.sv
// Shared op codes, FSM states and lane helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    OpLw  = 3'd0,
    OpLh  = 3'd1,
    OpLhu = 3'd2,
    OpLb  = 3'd3,
    OpLbu = 3'd4,
    OpSw  = 3'd5,
    OpSh  = 3'd6,
    OpSb  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StResp  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SzByte = 2'd0,
    SzHalf = 2'd1,
    SzWord = 2'd2
  } size_e;

  localparam int unsigned ByteW = 8;
  localparam int unsigned HalfW = 16;
  localparam int unsigned WordW = 32;

  function automatic size_e op_size(input op_e op);
    case (op)
      OpLw, OpSw:        op_size = SzWord;
      OpLh, OpLhu, OpSh: op_size = SzHalf;
      default:           op_size = SzByte;
    endcase
  endfunction

  function automatic logic op_is_load(input op_e op);
    case (op)
      OpLw, OpLh, OpLhu, OpLb, OpLbu: op_is_load = 1'b1;
      default:                        op_is_load = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_signed(input op_e op);
    op_is_signed = (op == OpLh) || (op == OpLb);
  endfunction

  function automatic logic op_misaligned(input op_e op, input logic [1:0] off);
    case (op_size(op))
      SzWord:  op_misaligned = (off != 2'b00);
      SzHalf:  op_misaligned = off[0];
      default: op_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Big-endian lane steering: merges a store lane into a word and extracts/extends a load lane.
module byte_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] store_i,
  input  logic [1:0]  offset_i,
  input  size_e       size_i,
  input  logic        signed_i,
  output logic [31:0] merged_o,
  output logic [31:0] loaded_o
);

  logic [4:0]  shamt;
  logic [31:0] mask;
  logic [31:0] lane;

  always_comb begin
    shamt = '0;
    mask  = '1;
    // Offset 0 is the most significant lane, so the shift is (last - offset) lanes.
    case (size_i)
      SzByte: begin
        shamt = {~offset_i, 3'b000};
        mask  = 32'h0000_00ff;
      end
      SzHalf: begin
        shamt = {~offset_i[1], 4'b0000};
        mask  = 32'h0000_ffff;
      end
      default: ;
    endcase

    merged_o = (word_i & ~(mask << shamt)) | ((store_i & mask) << shamt);
    lane     = word_i >> shamt;

    case (size_i)
      SzByte: loaded_o = signed_i ? {{(WordW - ByteW){lane[ByteW-1]}}, lane[ByteW-1:0]}
                                  : {{(WordW - ByteW){1'b0}}, lane[ByteW-1:0]};
      SzHalf: loaded_o = signed_i ? {{(WordW - HalfW){lane[HalfW-1]}}, lane[HalfW-1:0]}
                                  : {{(WordW - HalfW){1'b0}}, lane[HalfW-1:0]};
      default: loaded_o = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage requester for a word-only data memory; sub-word stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic [2:0]  Op,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic        Busy,
  output logic        Ack,
  output logic [31:0] LoadData,
  output logic        Err,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemReadData
);

  localparam logic [32:0] AddrLimit = 33'(MEM_WORDS) * 33'd4;

  state_e      state_q;
  op_e         op_q;
  logic [1:0]  off_q;
  logic [31:0] sdata_q;
  logic        busy_q, ack_q, err_q, mem_write_q, mem_read_q;
  logic [31:0] load_data_q, mem_addr_q, mem_wdata_q;

  op_e         req_op;
  logic        req_bad;
  logic [31:0] merged_word, loaded_word;

  assign req_op  = op_e'(Op);
  assign req_bad = op_misaligned(req_op, Addr[1:0]) || ({1'b0, Addr} >= AddrLimit);

  byte_lane_align u_align (
    .word_i   (MemReadData),
    .store_i  (sdata_q),
    .offset_i (off_q),
    .size_i   (op_size(op_q)),
    .signed_i (op_is_signed(op_q)),
    .merged_o (merged_word),
    .loaded_o (loaded_word)
  );

  // Every output is a register so async reset drops MemWrite before the closing edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      op_q        <= OpLw;
      off_q       <= '0;
      sdata_q     <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      load_data_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (Req) begin
            op_q    <= req_op;
            off_q   <= Addr[1:0];
            sdata_q <= StoreData;
            if (req_bad) begin
              err_q <= 1'b1;
            end else if (req_op == OpSw) begin
              state_q     <= StWrite;
              busy_q      <= 1'b1;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {Addr[31:2], 2'b00};
              mem_wdata_q <= StoreData;
            end else begin
              state_q    <= StRead;
              busy_q     <= 1'b1;
              mem_read_q <= 1'b1;
              mem_addr_q <= {Addr[31:2], 2'b00};
            end
          end
        end
        StRead: begin
          if (op_is_load(op_q)) begin
            load_data_q <= loaded_word;
            ack_q       <= 1'b1;
            state_q     <= StResp;
          end else begin
            mem_wdata_q <= merged_word;
            mem_write_q <= 1'b1;
            state_q     <= StWrite;
          end
        end
        StWrite: begin
          ack_q   <= 1'b1;
          state_q <= StResp;
        end
        StResp: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign Busy         = busy_q;
  assign Ack          = ack_q;
  assign Err          = err_q;
  assign LoadData     = load_data_q;
  assign MemAddress   = mem_addr_q;
  assign MemWriteData = mem_wdata_q;
  assign MemWrite     = mem_write_q;
  assign MemRead      = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a behavioural word memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        Clk, Reset, Req;
  logic [2:0]  Op;
  logic [31:0] Addr, StoreData;
  logic        Busy, Ack, Err, MemWrite, MemRead;
  logic [31:0] LoadData, MemAddress, MemWriteData, MemReadData;

  logic [31:0] mem [0:1023];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_load = '0;
  int          ack_count;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Req          (Req),
    .Op           (Op),
    .Addr         (Addr),
    .StoreData    (StoreData),
    .Busy         (Busy),
    .Ack          (Ack),
    .LoadData     (LoadData),
    .Err          (Err),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemReadData  (MemReadData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign MemReadData = mem[MemAddress[11:2]];
  always @(posedge Clk) if (MemWrite) mem[MemAddress[11:2]] <= MemWriteData;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one request for a single cycle; returns at the negedge of cycle T+1.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sd);
    @(negedge Clk);
    Req = 1'b1; Op = op; Addr = addr; StoreData = sd;
    @(negedge Clk);
    Req = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] exp);
    do_req(op, addr, 32'h0);
    chk({tag, " read"}, {31'b0, MemRead}, 32'd1);
    chk({tag, " nowr"}, {31'b0, MemWrite}, 32'd0);
    chk({tag, " addr"}, MemAddress, {addr[31:2], 2'b00});
    @(negedge Clk);
    chk({tag, " ack"}, {31'b0, Ack}, 32'd1);
    chk({tag, " data"}, LoadData, exp);
    chk({tag, " idle mem"}, {30'b0, MemRead, MemWrite}, 32'd0);
    last_load = exp;
    @(negedge Clk);
    chk({tag, " done"}, {30'b0, Busy, Ack}, 32'd0);
  endtask

  task automatic store_chk(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] exp_wdata);
    do_req(op, addr, sd);
    if (op != OpSw) begin
      chk({tag, " read"}, {30'b0, MemRead, MemWrite}, 32'd2);
      @(negedge Clk);
    end
    chk({tag, " write"}, {30'b0, MemRead, MemWrite}, 32'd1);
    chk({tag, " wdata"}, MemWriteData, exp_wdata);
    chk({tag, " waddr"}, MemAddress, {addr[31:2], 2'b00});
    chk({tag, " early ack"}, {31'b0, Ack}, 32'd0);
    @(negedge Clk);
    chk({tag, " ack"}, {31'b0, Ack}, 32'd1);
    chk({tag, " wr off"}, {31'b0, MemWrite}, 32'd0);
    chk({tag, " held load"}, LoadData, last_load);
    @(negedge Clk);
    chk({tag, " done"}, {30'b0, Busy, Ack}, 32'd0);
  endtask

  task automatic err_chk(input string tag, input logic [2:0] op, input logic [31:0] addr);
    do_req(op, addr, 32'hffff_ffff);
    chk({tag, " err"}, {31'b0, Err}, 32'd1);
    chk({tag, " busy"}, {31'b0, Busy}, 32'd0);
    chk({tag, " mem"}, {30'b0, MemRead, MemWrite}, 32'd0);
    @(negedge Clk);
    chk({tag, " err pulse"}, {31'b0, Err}, 32'd0);
    chk({tag, " ack"}, {30'b0, Ack, Busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0]    = 32'h1122_3344;
    mem[1]    = 32'h80ff_7f01;
    mem[1023] = 32'hdead_beef;
    Req = 1'b0; Op = '0; Addr = '0; StoreData = '0;
    Reset = 1'b0;
    #2 Reset = 1'b1;
    #2;
    chk("rst ctl", {28'b0, Busy, Ack, Err, MemWrite}, 32'd0);
    chk("rst rd", {31'b0, MemRead}, 32'd0);
    chk("rst ldata", LoadData, 32'd0);
    chk("rst maddr", MemAddress, 32'd0);
    chk("rst wdata", MemWriteData, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    load_chk("lw0", OpLw, 32'd0, 32'h1122_3344);
    load_chk("lb4", OpLb, 32'd4, 32'hffff_ff80);
    load_chk("lbu4", OpLbu, 32'd4, 32'h0000_0080);
    load_chk("lh6", OpLh, 32'd6, 32'h0000_7f01);
    load_chk("lh4", OpLh, 32'd4, 32'hffff_80ff);
    load_chk("lhu4", OpLhu, 32'd4, 32'h0000_80ff);
    load_chk("lb5", OpLb, 32'd5, 32'hffff_ffff);
    load_chk("lb7", OpLb, 32'd7, 32'h0000_0001);
    load_chk("lw top", OpLw, 32'd4092, 32'hdead_beef);
    load_chk("lh top", OpLh, 32'd4094, 32'hffff_beef);

    store_chk("sb2", OpSb, 32'd2, 32'h0000_00ab, 32'h1122_ab44);
    load_chk("lw0 rb", OpLw, 32'd0, 32'h1122_ab44);
    store_chk("sh6", OpSh, 32'd6, 32'h1234_cafe, 32'h80ff_cafe);
    load_chk("lw4 rb", OpLw, 32'd4, 32'h80ff_cafe);
    store_chk("sw12", OpSw, 32'd12, 32'ha5a5_0001, 32'ha5a5_0001);
    load_chk("lw12 rb", OpLw, 32'd12, 32'ha5a5_0001);

    err_chk("sh1", OpSh, 32'd1);
    err_chk("lw6", OpLw, 32'd6);
    err_chk("sw4096", OpSw, 32'd4096);
    err_chk("lb4096", OpLb, 32'd4096);
    chk("err mem0", mem[0], 32'h1122_ab44);
    chk("err mem1", mem[1], 32'h80ff_cafe);

    do_req(OpSw, 32'd8, 32'h0000_0014);
    chk("rstwr pre", {31'b0, MemWrite}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("rstwr wr", {31'b0, MemWrite}, 32'd0);
    chk("rstwr ctl", {28'b0, Busy, Ack, Err, MemRead}, 32'd0);
    chk("rstwr maddr", MemAddress, 32'd0);
    chk("rstwr wdata", MemWriteData, 32'd0);
    chk("rstwr ldata", LoadData, 32'd0);
    @(posedge Clk);
    #1;
    chk("rstwr mem8", mem[2], 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    last_load = '0;
    load_chk("lw8 after rst", OpLw, 32'd8, 32'h0000_0000);

    // Second request while busy must be dropped.
    @(negedge Clk);
    Req = 1'b1; Op = OpLw; Addr = 32'd0;
    @(negedge Clk);
    Addr = 32'd4;
    chk("busy req read", MemAddress, 32'd0);
    @(negedge Clk);
    Req = 1'b0;
    chk("busy req ack", {31'b0, Ack}, 32'd1);
    chk("busy req data", LoadData, 32'h1122_ab44);
    ack_count = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (Ack) ack_count++;
    end
    chk("busy req extra acks", ack_count, 32'd0);
    chk("busy req idle", {31'b0, Busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Pipeline-side requester for the word-wide DataMemory.
- Drives Address/WriteData/MemWrite/MemRead and consumes ReadData.
- Adds byte and halfword loads (sign/zero extended) and byte/halfword stores, using read-modify-write over the word-only memory.
- Sits between the MEM pipeline stage and DataMemory; stalls the pipeline via Busy.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in DataMemory; byte addresses >= MEM_WORDS*4 are out of range.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  1  request strobe; accepted only when Busy=0.
- Op  in  3  operation: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
- Addr  in  32  byte address.
- StoreData  in  32  store data; SH uses [15:0], SB uses [7:0].
- Busy  out  1  high whenever state != IDLE.
- Ack  out  1  one-cycle pulse when a load or store completes.
- LoadData  out  32  extended load result; valid while Ack=1, held until the next load Ack.
- Err  out  1  one-cycle pulse for a misaligned or out-of-range request.
- MemAddress  out  32  word-aligned address to DataMemory.
- MemWriteData  out  32  write word to DataMemory.
- MemWrite  out  1  DataMemory write enable.
- MemRead  out  1  DataMemory read enable.
- MemReadData  in  32  DataMemory read data; combinational from MemAddress.

Behaviour:
- Reset (async): state=IDLE. Busy, Ack, Err, MemWrite, MemRead = 0. LoadData, MemAddress, MemWriteData = 0. The latched request is cleared.
- Reset mid-operation aborts the access. MemWrite falls immediately, so no partial write reaches memory.
- Byte order is big-endian (MIPS): byte offset 0 = bits [31:24], offset 3 = bits [7:0]. Halfword offset 0 = [31:16], offset 2 = [15:0].
- IDLE: on Req=1, latch Op, Addr and StoreData.
  - Misaligned (LW/SW with Addr[1:0]!=0; LH/LHU/SH with Addr[0]!=0) or Addr >= MEM_WORDS*4: Err pulses next cycle, state stays IDLE, no memory access.
  - SW -> WRITE.
  - All other ops -> READ.
- Req while Busy=1 is ignored and not queued.
- READ (1 cycle): MemRead=1, MemAddress={Addr[31:2],2'b00}. Register MemReadData at the cycle end.
  - Loads -> RESP.
  - SH/SB -> WRITE.
- WRITE (1 cycle): MemWrite=1, MemAddress word-aligned.
  - MemWriteData = StoreData for SW.
  - For SH/SB, MemWriteData = the read word with the addressed lane replaced.
  - Memory commits on the closing edge; then -> RESP.
- RESP (1 cycle): Ack=1; LoadData updated for loads only; -> IDLE.
  - LH/LB sign-extend; LHU/LBU zero-extend.
- Latency, with Req accepted at cycle T:
  - Load: READ at T+1, Ack at T+2.
  - SW: WRITE at T+1, Ack at T+2.
  - SH/SB: READ at T+1, WRITE at T+2, Ack at T+3.
  - Error: Err at T+1.
- MemRead and MemWrite are never high in the same cycle. Both are 0 in IDLE and RESP.
- A new Req may be accepted in the cycle after RESP (IDLE). Back-to-back throughput is one op per 3 cycles (load/SW) or 4 cycles (SH/SB).
- All memory outputs are registered state decodes; no combinational path from Req to MemWrite.

Decomposition:
- Package lsu_pkg holds:
  - Op codes (OP_LW..OP_SB).
  - State encodings (IDLE, READ, WRITE, RESP).
  - Helper constants for lane widths.
- Sub-module byte_lane_align (combinational) provides:
  - Store merge: read word, StoreData, offset, size -> merged word.
  - Load extract: word, offset, size, signed -> 32-bit result.
- The FSM and registers live in load_store_unit.

Test Plan:
- Preload word 0 = 0x11223344. Req LW Addr=0 -> MemRead=1 at T+1, Ack at T+2, LoadData=0x11223344, MemWrite never high.
- Preload word 4 = 0x80FF7F01.
  - LB Addr=4 -> 0xFFFFFF80; LBU Addr=4 -> 0x00000080.
  - LH Addr=6 -> 0x00007F01; LH Addr=4 -> 0xFFFF80FF.
- Word 0 = 0x11223344. SB Addr=2 StoreData=0x000000AB -> READ T+1, MemWrite=1 only at T+2 with MemWriteData=0x1122AB44, Ack T+3. Readback LW gives 0x1122AB44.
- Misaligned and out-of-range requests -> Err pulse at T+1, Busy stays 0, no MemRead/MemWrite, memory unchanged:
  - SH Addr=1.
  - LW Addr=6.
  - SW Addr=4096 with MEM_WORDS=1024.
- SW Addr=8 StoreData=0x00000014; assert Reset during WRITE before the edge -> MemWrite drops immediately, word 8 unchanged, all outputs 0, state IDLE.
- Req LW during Busy (second Req at T+1 with a different Addr) -> ignored: exactly one Ack, LoadData from the first address.
